weight_loader_wq_weight_mmap_m_axi_req_arbiter: RTL and testbench

WEIGHT_LOADER_WQ_WEIGHT_MMAP_M_AXI_REQ_ARBITER -- requirements
Module: weight_loader_wq_weight_mmap_m_axi_req_arbiter

---
 rtl/weight_loader_wq_weight_mmap_m_axi_req_arbiter.sv | 120 ++++++++++++
 tb/tb_weight_loader_wq_weight_mmap_m_axi_req_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader_wq_weight_mmap_m_axi_req_arbiter.sv
// Request arbiter: picks one of NUM_REQ requesters per cycle and forwards it
// to the burst converter. It also keeps an ID FIFO that records the order of grants.
// Ports: clk/reset/clk_en; in_REQ_* are the packed requester inputs and
// out_REQ_READY is the per-requester accept strobe; out_ARB_* with
// in_ARB_READY form the registered converter port; out_RESP_ID* with
// in_RESP_DONE expose and retire the oldest outstanding request owner.
// Macro WEIGHT_LOADER_WQ_ARB_ROUND_ROBIN_EN: defined gives round-robin
// arbitration, undefined (the default) gives fixed priority, lowest index first.
module weight_loader_wq_weight_mmap_m_axi_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_DEPTH   = 8,
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clk_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] in_REQ_ADDR,
  input  logic [NUM_REQ*32-1:0]         in_REQ_LEN,
  input  logic [NUM_REQ-1:0]            in_REQ_VALID,
  output logic [NUM_REQ-1:0]            out_REQ_READY,
  output logic [ADDR_WIDTH-1:0]         out_ARB_ADDR,
  output logic [31:0]                   out_ARB_LEN,
  output logic                          out_ARB_VALID,
  input  logic                          in_ARB_READY,
  output logic [ID_WIDTH-1:0]           out_RESP_ID,
  output logic                          out_RESP_ID_VALID,
  input  logic                          in_RESP_DONE
);

  localparam int PW = (ID_DEPTH > 1) ? $clog2(ID_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [ID_WIDTH-1:0] win;
  logic [ID_WIDTH-1:0] id_mem [ID_DEPTH];
  logic [PW-1:0]       wptr;
  logic [PW-1:0]       rptr;
  logic [CW-1:0]       fifo_count;
  logic                full;
  logic                load;
  logic                pop;

`ifdef WEIGHT_LOADER_WQ_ARB_ROUND_ROBIN_EN
  logic [ID_WIDTH-1:0] rr_ptr;
  logic                found;
  int                  idx;

  // Scan starts at rr_ptr and wraps; the first valid requester wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && in_REQ_VALID[idx]) begin
        win   = ID_WIDTH'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (load)
      rr_ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
  end
`else
  // The scan runs downward so that the lowest valid index is the last match and wins.
  always_comb begin
    win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (in_REQ_VALID[i]) win = ID_WIDTH'(i);
  end
`endif

  assign full = (fifo_count == CW'(ID_DEPTH));

  // A full FIFO blocks load even when a pop happens in the same cycle.
  // Reset also forces load low so that the ready strobes stay quiet.
  assign load = ~reset & clk_en & (|in_REQ_VALID)
              & (~out_ARB_VALID | in_ARB_READY) & ~full;

  assign pop = in_RESP_DONE & clk_en & out_RESP_ID_VALID;

  assign out_REQ_READY = load ? (NUM_REQ'(1) << win) : '0;

  assign out_RESP_ID_VALID = (fifo_count != '0);
  assign out_RESP_ID = out_RESP_ID_VALID ? id_mem[rptr] : '0;

  always_ff @(posedge clk) begin
    if (load) id_mem[wptr] <= win;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_ARB_VALID <= 1'b0;
      out_ARB_ADDR  <= '0;
      out_ARB_LEN   <= '0;
      wptr          <= '0;
      rptr          <= '0;
      fifo_count    <= '0;
    end else begin
      if (load) begin
        out_ARB_ADDR  <= in_REQ_ADDR[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        out_ARB_LEN   <= in_REQ_LEN[int'(win)*32 +: 32];
        out_ARB_VALID <= 1'b1;
        wptr          <= wptr + 1'b1;
      end else if (out_ARB_VALID & in_ARB_READY & clk_en) begin
        out_ARB_VALID <= 1'b0;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (load & ~pop)
        fifo_count <= fifo_count + 1'b1;
      else if (pop & ~load)
        fifo_count <= fifo_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_weight_loader_wq_weight_mmap_m_axi_req_arbiter.sv
// Directed bench for the request arbiter.
// The checks use immediate assertions with expected values worked out by hand.
module tb_weight_loader_wq_weight_mmap_m_axi_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            clk_en;
  logic [N*AW-1:0] req_addr;
  logic [N*32-1:0] req_len;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   arb_addr;
  logic [31:0]     arb_len;
  logic            arb_valid;
  logic            arb_ready;
  logic [IW-1:0]   resp_id;
  logic            resp_id_valid;
  logic            resp_done;

  int checks = 0;
  int errors = 0;

  weight_loader_wq_weight_mmap_m_axi_req_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .ID_DEPTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_en(clk_en),
    .in_REQ_ADDR(req_addr),
    .in_REQ_LEN(req_len),
    .in_REQ_VALID(req_valid),
    .out_REQ_READY(req_ready),
    .out_ARB_ADDR(arb_addr),
    .out_ARB_LEN(arb_len),
    .out_ARB_VALID(arb_valid),
    .in_ARB_READY(arb_ready),
    .out_RESP_ID(resp_id),
    .out_RESP_ID_VALID(resp_id_valid),
    .in_RESP_DONE(resp_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_done();
    resp_done = 1'b1;
    tick();
    resp_done = 1'b0;
    tick();
  endtask

  task automatic drain();
    for (int g = 0; g < 16 && resp_id_valid; g++) pulse_done();
    chk("drain_empty", 64'(resp_id_valid), 64'd0);
  endtask

  initial begin
    int exp_id [8];
    reset     = 1'b1;
    clk_en    = 1'b1;
    req_addr  = '0;
    req_len   = '0;
    req_valid = '0;
    arb_ready = 1'b1;
    resp_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_arb_valid", 64'(arb_valid), 64'd0);
    chk("rst_arb_addr", 64'(arb_addr), 64'd0);
    chk("rst_arb_len", 64'(arb_len), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_id_valid", 64'(resp_id_valid), 64'd0);
    chk("rst_id", 64'(resp_id), 64'd0);

    // A lone request from requester 2 appears on the converter port one cycle later.
    req_addr[2*AW +: AW] = 32'h1000;
    req_len[2*32 +: 32]  = 32'd255;
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    #1;
    chk("single_ready_drop", 64'(req_ready), 64'h0);
    chk("single_addr", 64'(arb_addr), 64'h1000);
    chk("single_len", 64'(arb_len), 64'd255);
    chk("single_valid", 64'(arb_valid), 64'd1);
    chk("single_id", 64'(resp_id), 64'd2);
    tick();
    chk("single_valid_clr", 64'(arb_valid), 64'd0);
    pulse_done();
    chk("single_pop", 64'(resp_id_valid), 64'd0);
    // A done pulse while the FIFO is empty must be ignored.
    pulse_done();
    chk("empty_done", 64'(resp_id_valid), 64'd0);

    // clk_en low stalls acceptance entirely.
    clk_en = 1'b0;
    req_valid = 4'b0001;
    #1;
    chk("clk_en_ready", 64'(req_ready), 64'h0);
    tick();
    chk("clk_en_hold", 64'(arb_valid), 64'd0);
    clk_en = 1'b1;
    req_valid = '0;
    do_reset();

`ifdef WEIGHT_LOADER_WQ_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 32'(i * 256);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk("rr_addr", 64'(arb_addr), 64'((k % 4) * 256));
    end
    req_valid = '0;
    drain();
`else
    req_addr[0*AW +: AW] = 32'h2000;
    req_len[0*32 +: 32]  = 32'd16;
    req_addr[3*AW +: AW] = 32'h3000;
    req_len[3*32 +: 32]  = 32'd48;
    req_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("fp_ready", 64'(req_ready), 64'h1);
      tick();
      chk("fp_addr", 64'(arb_addr), 64'h2000);
      chk("fp_id", 64'(resp_id), 64'd0);
    end
    req_valid = '0;
    drain();
`endif

    // Backpressure: the pending request stays put and no new one is accepted.
    do_reset();
    req_addr[0*AW +: AW] = 32'h4000;
    req_len[0*32 +: 32]  = 32'd7;
    req_valid = 4'b0001;
    #1;
    chk("bp_first_ready", 64'(req_ready), 64'h1);
    tick();
    req_addr[1*AW +: AW] = 32'h5000;
    req_len[1*32 +: 32]  = 32'd9;
    req_valid = 4'b0010;
    arb_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_no_ready", 64'(req_ready), 64'h0);
      chk("bp_addr", 64'(arb_addr), 64'h4000);
      chk("bp_len", 64'(arb_len), 64'd7);
      tick();
    end
    arb_ready = 1'b1;
    #1;
    chk("bp_resume", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    chk("bp_new_addr", 64'(arb_addr), 64'h5000);
    chk("bp_new_len", 64'(arb_len), 64'd9);
    tick();
    drain();

    // Fill the ID FIFO with eight grants, then check that it blocks and releases.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req_valid = 4'(1 << (i % 4));
      exp_id[i] = i % 4;
      #1;
      chk("full_fill_ready", 64'(req_ready), 64'(4'b0001 << (i % 4)));
      tick();
    end
    req_valid = 4'b0001;
    #1;
    chk("full_block", 64'(req_ready), 64'h0);
    tick();
    chk("full_block2", 64'(req_ready), 64'h0);
    chk("full_head", 64'(resp_id), 64'(exp_id[0]));
    resp_done = 1'b1;
    #1;
    chk("full_block_pop", 64'(req_ready), 64'h0);
    tick();
    resp_done = 1'b0;
    #1;
    chk("full_ninth", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    for (int i = 1; i < 8; i++) begin
      chk("full_pop_order", 64'(resp_id), 64'(exp_id[i]));
      pulse_done();
    end
    chk("full_ninth_id", 64'(resp_id), 64'd0);
    pulse_done();
    chk("full_empty", 64'(resp_id_valid), 64'd0);

    // Reset with three IDs outstanding and a request stalled on the port.
    do_reset();
    for (int i = 3; i >= 1; i--) begin
      req_valid = 4'(1 << i);
      tick();
    end
    req_valid = '0;
    arb_ready = 1'b0;
    chk("mid_pre_valid", 64'(resp_id_valid), 64'd1);
    chk("mid_pre_id", 64'(resp_id), 64'd3);
    reset  = 1'b1;
    clk_en = 1'b0;
    tick();
    reset  = 1'b0;
    clk_en = 1'b1;
    #1;
    chk("mid_id_valid", 64'(resp_id_valid), 64'd0);
    chk("mid_arb_valid", 64'(arb_valid), 64'd0);
    arb_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("mid_next_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    chk("mid_next_id", 64'(resp_id), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
